muxn_skid: RTL
==============

Name: muxn_skid

Overview:
- Parametrised N-way data selector, the registered successor of the combinational 2/3-input select muxes used in the pipeline datapath.
- Selects one of N WIDTH-bit inputs by an encoded select and registers the result.
- Valid/ready handshake with a 2-entry skid buffer, so it can sit between pipeline stages without a combinational ready path.
- Flags out-of-range selects per beat and stickily, and supports a synchronous flush for pipeline redirects.

Parameters:
- WIDTH, 64, data width of each input and the output.
- N, 4, number of data inputs (legal range 2..16).
- SELW, $clog2(N), select width (derived; not overridden).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous reset, active-high.
- flush  in  1  synchronous discard of all buffered beats.
- d  in  N*WIDTH  packed inputs; input i occupies bits [i*WIDTH +: WIDTH].
- sel  in  SELW  index of the input to pass.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  block can accept a beat this cycle.
- y  out  WIDTH  selected data of the head beat.
- y_err  out  1  head beat had sel >= N.
- out_valid  out  1  head beat present.
- out_ready  in  1  downstream accepts the head beat.
- err_seen  out  1  sticky: some accepted beat had sel >= N.

Behaviour:
- Select function: sel < N gives d[sel]; sel >= N gives all-zero data with the error bit set. Possible only when N is not a power of 2.
- Input fire = in_valid & in_ready; output fire = out_valid & out_ready.
- in_ready is 0 while reset is high and 1 when the skid entry is empty. It is registered and must not depend combinationally on out_ready.
- Storage: main entry (head, drives y/y_err) and skid entry, each holding {data, err}.
- States are EMPTY, ONE and FULL:
  - EMPTY: in fire loads main and goes to ONE.
  - ONE, in fire only: loads skid and goes to FULL.
  - ONE, out fire only: goes to EMPTY.
  - ONE, in fire and out fire together: main is reloaded with the new beat and the state stays ONE.
  - FULL: in_ready = 0. Out fire moves skid to main and goes to ONE.
- Latency: a beat accepted in cycle t is visible on y/out_valid in cycle t+1 (minimum 1). Throughput is 1 beat/cycle with out_ready held high.
- Ordering: strict FIFO; no beat is lost or duplicated except by flush.
- out_valid = (state != EMPTY). y and y_err are stable while out_valid & ~out_ready.
- Cleared data: y reads 0 when EMPTY, and the payload registers are cleared on leaving ONE to EMPTY.
- flush: next state EMPTY, y = 0, y_err = 0.
  - A beat presented in the flush cycle is dropped even if in_valid & in_ready.
  - An out fire in the flush cycle still counts as delivered downstream.
  - flush does not clear err_seen.
- err_seen: set on any in fire with sel >= N (including the flush cycle); cleared only by reset.
- Reset (synchronous, dominates flush and handshakes): state EMPTY, out_valid 0, y 0, y_err 0, err_seen 0, in_ready 0 in the reset cycle and 1 from the next cycle.
- Reset asserted mid-stream discards all buffered beats with no partial outputs.
- No X propagation: unused payload bits are held at 0.

Decomposition:
- Shared package (common):
  - Add the skid state enum (EMPTY/ONE/FULL, 2 bits).
  - Add a payload struct {data, err} parametrised by the width typedef.
  - Reuse the existing u1/u2 scalar typedefs.
- Sub-module skid_buf (WIDTH+1 payload): holds the handshake, storage and state machine, and has no knowledge of selection.
- muxn_skid contains the combinational N-way select/err generation, the skid_buf instance and the err_seen register.

Test Plan:
- N=4, WIDTH=64, d = {0x44,0x33,0x22,0x11}, sel=2, in_valid=1, out_ready=1 -> y=0x33, y_err=0 one cycle later; continuous 1 beat/cycle thereafter.
- Backpressure:
  - Push beats A, B, C with out_ready=0 -> in_ready drops after B, C is held upstream.
  - Raise out_ready -> outputs A, B, C in order with no loss.
- N=3, sel=3 -> y=0, y_err=1 on that beat, err_seen=1 and remaining 1 after subsequent legal beats.
- FULL with A, B buffered, assert flush with C offered -> next cycle out_valid=0, y=0, C not delivered, in_ready=1; err_seen unchanged.
- Reset during FULL -> next cycle out_valid=0, y=0, err_seen=0, and in_ready=1 one cycle after reset deasserts.
- Simultaneous in fire and out fire in ONE -> state stays ONE, y shows the new beat next cycle; 1000-cycle random valid/ready check against a reference queue model.

Source files
------------

// File: rtl/muxn_skid_pkg.sv
// Shared types for the registered N-way selector and its skid buffer.
package muxn_skid_pkg;

  typedef logic       u1;
  typedef logic [1:0] u2;

  // Occupancy of the two-entry skid buffer.
  typedef enum u2 {
    SK_EMPTY = 2'd0,
    SK_ONE   = 2'd1,
    SK_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/muxn_skid_buf.sv
// Two-entry skid buffer with registered in_ready and synchronous flush.
// Carries an opaque payload; knows nothing about selection.
module skid_buf
  import muxn_skid_pkg::*;
#(
  parameter int PW = 65
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic [PW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [PW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  skid_state_e   state_reg, state_next;
  logic [PW-1:0] main_reg, main_next;
  logic [PW-1:0] skid_reg, skid_next;
  logic          in_ready_reg;
  logic          in_fire, out_fire;

  // Gating with reset keeps in_ready low in the reset cycle itself.
  assign in_ready  = in_ready_reg & ~reset;
  assign out_valid = (state_reg != SK_EMPTY);
  assign out_data  = main_reg;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    case (state_reg)
      SK_EMPTY: begin
        if (in_fire) begin
          main_next  = in_data;
          state_next = SK_ONE;
        end
      end
      SK_ONE: begin
        if (in_fire && out_fire) begin
          main_next = in_data;
        end else if (in_fire) begin
          skid_next  = in_data;
          state_next = SK_FULL;
        end else if (out_fire) begin
          main_next  = '0;
          state_next = SK_EMPTY;
        end
      end
      SK_FULL: begin
        if (out_fire) begin
          main_next  = skid_reg;
          skid_next  = '0;
          state_next = SK_ONE;
        end
      end
      default: begin
        main_next  = '0;
        skid_next  = '0;
        state_next = SK_EMPTY;
      end
    endcase
    // Flush discards everything, including a beat accepted this cycle.
    if (flush) begin
      main_next  = '0;
      skid_next  = '0;
      state_next = SK_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= SK_EMPTY;
      main_reg     <= '0;
      skid_reg     <= '0;
      in_ready_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      main_reg     <= main_next;
      skid_reg     <= skid_next;
      in_ready_reg <= (state_next != SK_FULL);
    end
  end

endmodule

// File: rtl/muxn_skid.sv
// Registered N-way data selector with out-of-range flagging, behind a
// two-entry skid buffer so ready never depends combinationally on out_ready.
module muxn_skid
  import muxn_skid_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic [N*WIDTH-1:0] d,
  input  logic [SELW-1:0]    sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   y,
  output logic               y_err,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               err_seen
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    u1                err;
  } payload_t;

  logic [WIDTH-1:0] lane [N];
  payload_t         sel_beat, head_beat;
  logic             err_seen_reg;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      assign lane[gi] = d[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Out-of-range selects produce zero data so no stale lane leaks through.
  always_comb begin
    sel_beat = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == SELW'(i)) sel_beat.data = lane[i];
    end
    sel_beat.err = (int'(sel) >= N);
  end

  skid_buf #(
    .PW(WIDTH + 1)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_data   (sel_beat),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (head_beat),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign y     = head_beat.data;
  assign y_err = head_beat.err;

  // Sticky across flush; a flushed bad beat still counts as seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_seen_reg <= 1'b0;
    end else if (in_valid && in_ready && sel_beat.err) begin
      err_seen_reg <= 1'b1;
    end
  end

  assign err_seen = err_seen_reg;

endmodule
